// File: rtl/dmem_mmio_responder.sv
// Load/store responder for the core's data port: byte-enabled RAM plus an MMIO page
// with a free-running cycle counter, a TX byte FIFO and a status register.
module dmem_mmio_responder #(
  parameter int unsigned MEM_WORDS  = 1024,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  input  logic [3:0]  dwe,
  output logic [31:0] drdata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [5:0] OFF_CYCLE  = 6'h00;
  localparam logic [5:0] OFF_TXDATA = 6'h01;
  localparam logic [5:0] OFF_STATUS = 6'h02;

  logic [31:0]   mem_q  [MEM_WORDS];
  logic [7:0]    fifo_q [FIFO_DEPTH];

  logic [31:0]   cyc_q, cyc_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  logic          is_mmio;
  logic [AW-1:0] ram_idx;
  logic [5:0]    mmio_off;
  logic          mmio_wr;
  logic          ram_wr;
  logic          empty;
  logic          full;
  logic          push_req;
  logic          push_ok;
  logic          pop;

  // Address bits outside the decoded fields alias onto the same locations.
  logic          unused_addr_bits;
  assign unused_addr_bits = ^{daddr[30:AW+2], daddr[1:0]};

  assign is_mmio  = daddr[31];
  assign ram_idx  = daddr[AW+1:2];
  assign mmio_off = daddr[7:2];
  assign mmio_wr  = is_mmio && !reset;
  assign ram_wr   = !is_mmio && !reset;

  assign empty    = (count_q == CW'(0));
  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign tx_valid = !empty;
  assign tx_data  = empty ? 8'h00 : fifo_q[rd_ptr_q];

  // Room is judged on start-of-cycle occupancy; a same-cycle pop never frees a slot.
  assign push_req = mmio_wr && (mmio_off == OFF_TXDATA) && dwe[0];
  assign push_ok  = push_req && !full;
  assign pop      = tx_valid && tx_ready;

  always_comb begin
    cyc_d    = cyc_q + 32'd1;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(push_ok) - CW'(pop);
    ovf_d    = ovf_q;

    if (mmio_wr && (mmio_off == OFF_CYCLE) && (dwe == 4'hF)) begin
      cyc_d = dwdata;
    end
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push_req && full) begin
      ovf_d = 1'b1;
    end
    if (mmio_wr && (mmio_off == OFF_STATUS) && dwe[0] && dwdata[2]) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      cyc_q    <= cyc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage arrays carry no reset; RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_q[wr_ptr_q] <= dwdata[7:0];
    end
    for (int i = 0; i < 4; i++) begin
      if (ram_wr && dwe[i]) begin
        mem_q[ram_idx][8*i +: 8] <= dwdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    drdata = '0;
    if (!is_mmio) begin
      drdata = mem_q[ram_idx];
    end else begin
      case (mmio_off)
        OFF_CYCLE:  drdata = cyc_q;
        OFF_STATUS: drdata = {29'b0, ovf_q, full, empty};
        default:    drdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Self-checking bench for dmem_mmio_responder: RAM vector table, cycle counter,
// and a TX scoreboard fed at push time and drained by a stream monitor.
module tb_dmem_mmio_responder;

  localparam logic [31:0] A_CYCLE  = 32'h8000_0000;
  localparam logic [31:0] A_TXDATA = 32'h8000_0004;
  localparam logic [31:0] A_STATUS = 32'h8000_0008;

  logic        clk;
  logic        reset;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  dwe;
  logic [31:0] drdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q [$];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [13];

  dmem_mmio_responder #(.MEM_WORDS(1024), .FIFO_DEPTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .daddr    (daddr),
    .dwdata   (dwdata),
    .dwe      (dwe),
    .drdata   (drdata),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Every accepted byte must match the oldest scoreboard entry.
  always @(negedge clk) begin
    if (!reset && tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL tx_unexpected: got %h, want no byte", tx_data);
      end else begin
        chk("tx_byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    vecs[0]  = '{32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0};
    vecs[1]  = '{32'h0000_0010, 32'h0,         4'h0, 1'b1, 32'hDEAD_BEEF};
    vecs[2]  = '{32'h0000_0010, 32'h0055_0000, 4'h4, 1'b1, 32'hDEAD_BEEF};
    vecs[3]  = '{32'h0000_0010, 32'h0,         4'h0, 1'b1, 32'hDE55_BEEF};
    vecs[4]  = '{32'h0000_1000, 32'h1234_5678, 4'hF, 1'b0, 32'h0};
    vecs[5]  = '{32'h0000_0000, 32'h0,         4'h0, 1'b1, 32'h1234_5678};
    vecs[6]  = '{32'h7FFF_F000, 32'h0,         4'h0, 1'b1, 32'h1234_5678};
    vecs[7]  = '{32'h0000_0024, 32'hAABB_CCDD, 4'hF, 1'b0, 32'h0};
    vecs[8]  = '{32'h0000_0024, 32'h0000_0011, 4'h1, 1'b1, 32'hAABB_CCDD};
    vecs[9]  = '{32'h0000_0024, 32'h0,         4'h0, 1'b1, 32'hAABB_CC11};
    vecs[10] = '{32'h8000_000C, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0};
    vecs[11] = '{32'h8000_0004, 32'h0,         4'h0, 1'b1, 32'h0};
    vecs[12] = '{32'hFFFF_FF08, 32'h0,         4'h0, 1'b1, 32'h0000_0001};

    reset = 1'b1; daddr = A_STATUS; dwdata = '0; dwe = 4'h0; tx_ready = 1'b0;
    step(); step();
    @(negedge clk);
    chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
    chk("rst_status", drdata, 32'h1);

    // Counter: 10 cycles after release, then load and wrap.
    step();
    reset = 1'b0;
    repeat (10) step();
    daddr = A_CYCLE;
    @(negedge clk);
    chk("cycle_10", drdata, 32'd10);
    step();
    daddr = A_CYCLE; dwdata = 32'hFFFF_FFFF; dwe = 4'hF;
    step();
    dwe = 4'h0;
    @(negedge clk);
    chk("cycle_load", drdata, 32'hFFFF_FFFF);
    step();
    @(negedge clk);
    chk("cycle_wrap", drdata, 32'h0);
    step();

    // RAM and MMIO decode vectors.
    for (int i = 0; i < 13; i++) begin
      daddr = vecs[i].addr; dwdata = vecs[i].wdata; dwe = vecs[i].we;
      @(negedge clk);
      if (vecs[i].chk) chk($sformatf("vec%0d", i), drdata, vecs[i].exp);
      step();
    end
    dwe = 4'h0;

    // Overflow with ready low, then drain in order.
    begin
      int cnt = 0;
      tx_ready = 1'b0;
      for (int b = 0; b < 9; b++) begin
        daddr = A_TXDATA; dwdata = 32'(8'h41 + b); dwe = 4'h1;
        if (cnt < 8) begin
          exp_q.push_back(8'(8'h41 + b));
          cnt++;
        end
        step();
      end
    end
    dwe = 4'h0; daddr = A_STATUS;
    @(negedge clk);
    chk("status_full_ovf", drdata, 32'h6);
    step();
    tx_ready = 1'b1;
    repeat (8) step();
    @(negedge clk);
    chk("drain_valid_low", {31'h0, tx_valid}, 32'h0);
    chk("status_empty_ovf", drdata, 32'h5);
    chk("drain_all_seen", 32'(exp_q.size()), 32'h0);
    step();
    daddr = A_STATUS; dwdata = 32'h4; dwe = 4'h1;
    step();
    dwe = 4'h0;
    @(negedge clk);
    chk("status_ovf_cleared", drdata, 32'h1);
    step();

    // Push while full with a same-cycle pop: push is dropped.
    tx_ready = 1'b0;
    for (int b = 0; b < 8; b++) begin
      daddr = A_TXDATA; dwdata = 32'(8'h61 + b); dwe = 4'h1;
      exp_q.push_back(8'(8'h61 + b));
      step();
    end
    tx_ready = 1'b1; daddr = A_TXDATA; dwdata = 32'h5A; dwe = 4'h1;
    step();
    tx_ready = 1'b0; dwe = 4'h0; daddr = A_STATUS;
    @(negedge clk);
    chk("full_pop_push_status", drdata, 32'h4);
    step();
    tx_ready = 1'b1;
    repeat (6) step();
    @(negedge clk);
    chk("count7_still_valid", {31'h0, tx_valid}, 32'h1);
    step();
    @(negedge clk);
    chk("count7_drained", {31'h0, tx_valid}, 32'h0);
    chk("count7_status", drdata, 32'h5);
    tx_ready = 1'b0;
    step();

    // Reset mid-operation with bytes queued and overflow set.
    daddr = 32'h0000_0020; dwdata = 32'hCAFE_F00D; dwe = 4'hF;
    step();
    for (int b = 0; b < 3; b++) begin
      daddr = A_TXDATA; dwdata = 32'(8'h71 + b); dwe = 4'h1;
      exp_q.push_back(8'(8'h71 + b));
      step();
    end
    dwe = 4'h0;
    @(negedge clk);
    chk("pre_rst_valid", {31'h0, tx_valid}, 32'h1);
    chk("pre_rst_head", {24'h0, tx_data}, 32'h71);
    step();
    reset = 1'b1; daddr = 32'h0000_0020; dwdata = 32'h1111_1111; dwe = 4'hF;
    step();
    exp_q.delete();
    reset = 1'b0; dwe = 4'h0; daddr = A_CYCLE;
    @(negedge clk);
    chk("post_rst_cycle", drdata, 32'h0);
    chk("post_rst_valid", {31'h0, tx_valid}, 32'h0);
    chk("post_rst_data", {24'h0, tx_data}, 32'h0);
    step();
    daddr = A_STATUS;
    @(negedge clk);
    chk("post_rst_status", drdata, 32'h1);
    daddr = 32'h0000_0020;
    #1;
    chk("post_rst_ram", drdata, 32'hCAFE_F00D);
    step();

    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
